// File: rtl/fifo_uart_tx.sv
// UART transmitter fed directly from a synchronous FIFO read port.
// Pops one byte per frame and serialises it: start, data LSB first, optional even parity, stop.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_par;
  logic                  r_tx;
  logic                  r_done;
  logic                  w_tx_next;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_pop;

  assign w_bit_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit == BIT_W'(DATA_WIDTH - 1));
  assign w_pop      = (r_state == IDLE) && !fifo_empty && !rst;

  assign fifo_rd_en = w_pop;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign tx_done    = r_done;

  always_comb begin
    w_next       = r_state;
    w_shift_next = r_shift;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_next       = START;
          w_shift_next = fifo_rd_data;
        end
      end
      START: begin
        if (w_bit_end) w_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (w_last_bit) w_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_bit_end) w_next = STOP;
      end
      STOP: begin
        if (w_bit_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // tx is registered from the next state so the line level lands together with the state change
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = r_par;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= (r_state == STOP) && w_bit_end;
      if (w_pop) r_par <= ^fifo_rd_data;
      if (r_state == IDLE || w_bit_end) r_baud <= '0;
      else                               r_baud <= r_baud + 1'b1;
      if (r_state == DATA && w_bit_end) r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
    end
  end

  a_pop_not_empty : assert property (@(posedge clk) fifo_rd_en |-> !fifo_empty);
  a_pop_in_idle   : assert property (@(posedge clk) fifo_rd_en |-> (r_state == IDLE));
  a_idle_line_hi  : assert property (@(posedge clk) disable iff (rst) (r_state == IDLE) |-> r_tx);
  a_busy_fall     : assert property (@(posedge clk) disable iff (rst)
                                     $fell(busy) |-> (tx_done || $past(rst)));

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames, a serial monitor decodes tx and compares.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       rd_en, tx, busy, tx_done;

  logic       p_empty = 1'b1;
  logic [7:0] p_data  = 8'h00;
  logic       p_rd_en, p_tx, p_busy, p_done;

  logic [7:0] mem [16];
  int         wp = 0;
  int         rp = 0;
  logic       hold_empty = 1'b0;

  int         errors = 0;
  int         checks = 0;
  int         cyc_n  = 0;
  int         npop   = 0;
  int         last_pop = 0, prev_pop = 0;
  int         last_st  = 0, prev_st  = 0;
  int         done0 = 0, done1 = 0;

  logic [8:0] exp0 [$];
  logic [8:0] exp1 [$];

  assign fifo_empty   = (rp == wp) || hold_empty;
  assign fifo_rd_data = mem[rp % 16];

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .fifo_empty(p_empty), .fifo_rd_data(p_data),
    .fifo_rd_en(p_rd_en), .tx(p_tx), .busy(p_busy), .tx_done(p_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // FIFO model: pop pointer advances on the DUT's pop edge
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rd_en) begin
      rp       <= rp + 1;
      npop     <= npop + 1;
      prev_pop <= last_pop;
      last_pop <= cyc_n;
    end
  end

  // Serial monitor: samples both lines mid-cycle and decodes whole frames
  logic [43:0] smp  [2];
  int          mcyc [2];
  bit          inf  [2] = '{1'b0, 1'b0};

  task automatic check_frame(input int u, input int nb);
    logic       hold_ok;
    logic [7:0] got;
    logic [8:0] e;
    hold_ok = 1'b1;
    for (int b = 0; b < nb; b++)
      for (int k = 1; k < 4; k++)
        if (smp[u][4*b+k] !== smp[u][4*b]) hold_ok = 1'b0;
    chk($sformatf("bit_hold_u%0d", u), 32'(hold_ok), 32'd1);
    chk($sformatf("stop_bit_u%0d", u), 32'(smp[u][4*(nb-1)]), 32'd1);
    for (int i = 0; i < 8; i++) got[i] = smp[u][4*(i+1)];
    if ((u == 0 && exp0.size() == 0) || (u == 1 && exp1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame_u%0d: got byte %0h expected no frame", u, got);
    end else begin
      e = (u == 0) ? exp0.pop_front() : exp1.pop_front();
      chk($sformatf("byte_u%0d", u), 32'(got), 32'(e[7:0]));
      if (u == 1) chk("parity_bit", 32'(smp[1][36]), 32'(e[8]));
    end
  endtask

  always @(negedge clk) begin
    if (tx_done) done0++;
    if (p_done)  done1++;
    if (rd_en)   chk("pop_while_busy_or_rst", {30'd0, busy, rst}, 32'd0);
    if (p_rd_en) chk("p_pop_while_busy_or_rst", {30'd0, p_busy, rst}, 32'd0);
    for (int u = 0; u < 2; u++) begin
      logic t;
      int   nb;
      t  = (u == 0) ? tx : p_tx;
      nb = (u == 0) ? 10 : 11;
      if (rst) begin
        inf[u] = 1'b0;
      end else if (!inf[u]) begin
        if (!t) begin
          inf[u]       = 1'b1;
          smp[u]       = '1;
          smp[u][0]    = t;
          mcyc[u]      = 1;
          if (u == 0) begin
            prev_st = last_st;
            last_st = cyc_n;
          end
        end
      end else begin
        smp[u][mcyc[u]] = t;
        mcyc[u]++;
        if (mcyc[u] == nb*4) begin
          check_frame(u, nb);
          inf[u] = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit expect_frame);
    mem[wp % 16] = d;
    wp++;
    if (expect_frame) exp0.push_back({1'b0, d});
  endtask

  task automatic wait_done(input int unit, input int target);
    int n;
    n = 0;
    while ((((unit == 0) ? done0 : done1) < target) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL timeout_u%0d: got %0d tx_done pulses expected %0d", unit, (unit == 0) ? done0 : done1, target);
    end
  endtask

  initial begin
    int d0, d1, np;

    // Reset with a byte already waiting
    push(8'h3C, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_pop", 32'(rd_en), 32'd0);
    end
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_p_tx", 32'(p_tx), 32'd1);
    rst = 1'b0;
    wait_done(0, 1);

    // Single byte 0xA5
    d0 = done0;
    np = npop;
    push(8'hA5, 1'b1);
    wait_done(0, d0 + 1);
    repeat (10) tick();
    chk("a5_pops", 32'(npop - np), 32'd1);
    chk("a5_done_pulses", 32'(done0 - d0), 32'd1);
    chk("a5_busy_after", 32'(busy), 32'd0);

    // Back-to-back 0x00, 0xFF
    d0 = done0;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_done(0, d0 + 2);
    tick();
    chk("b2b_pop_spacing", 32'(last_pop - prev_pop), 32'd41);
    chk("b2b_start_spacing", 32'(last_st - prev_st), 32'd41);

    // Even parity on the second instance
    d1 = done1;
    exp1.push_back({1'b1, 8'h07});
    exp1.push_back({1'b0, 8'h03});
    p_data  = 8'h07;
    p_empty = 1'b0;
    tick();
    p_empty = 1'b1;
    wait_done(1, d1 + 1);
    p_data  = 8'h03;
    p_empty = 1'b0;
    tick();
    p_empty = 1'b1;
    wait_done(1, d1 + 2);

    // Reset during data bit 3 of 0x5A, then 0xC3 must go out intact
    d0 = done0;
    np = npop;
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b1);
    tick();
    repeat (17) tick();
    chk("abort_bit3_level", 32'(tx), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_pop_in_rst", 32'(rd_en), 32'd0);
    chk("abort_no_done", 32'(done0 - d0), 32'd0);
    rst = 1'b0;
    wait_done(0, d0 + 1);
    repeat (3) tick();
    chk("abort_pops", 32'(npop - np), 32'd2);

    // fifo_empty toggling mid-frame
    d0 = done0;
    hold_empty = 1'b1;
    push(8'h81, 1'b1);
    push(8'h42, 1'b1);
    hold_empty = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin
      hold_empty = ~hold_empty;
      tick();
    end
    hold_empty = 1'b0;
    wait_done(0, d0 + 2);
    tick();
    chk("toggle_pop_spacing", 32'(last_pop - prev_pop), 32'd41);

    repeat (5) tick();
    chk("exp0_drained", 32'(exp0.size()), 32'd0);
    chk("exp1_drained", 32'(exp1.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_p_busy", 32'(p_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
